core_regs_banked: RTL and testbench

Parametrised register file for the core: configurable data width, register count and number of read ports, built as one memory copy per read port, all written in lockstep, so each copy maps to a two-port block RAM. After reset it runs a clear sequencer that zeroes every entry, then serves registered reads with write-first bypass. It raises a one-cycle branch flag whenever the program-counter register is written. It sits between decode (read addresses) and writeback (write port).

---
 rtl/core_regs_banked.sv | 130 +++++++++++++
 tb/tb_core_regs_banked.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/core_regs_banked.sv
// Banked register file: one memory copy per read port, all written together,
// with a post-reset clear sequencer, write-first read bypass and a PC-write flag.
module core_regs_banked #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned READ_PORTS     = 2,
  parameter int unsigned PC_INDEX       = DEPTH - 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [READ_PORTS*$clog2(DEPTH)-1:0] rd_r,
  output logic [READ_PORTS*WIDTH-1:0]      rd_value,
  input  logic [$clog2(DEPTH)-1:0]         wr_r,
  input  logic                             wr_enable,
  input  logic [WIDTH-1:0]                 wr_value,
  output logic [WIDTH-1:0]                 wr_current,
  output logic                             branch,
  output logic                             ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PC_AW   = AW'(PC_INDEX);
  localparam logic [AW-1:0] LAST_AW = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              branch_q, branch_d;
  logic [WIDTH-1:0]  wr_current_q, wr_current_d;

  logic              clearing;
  logic              wr_accept;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ready_d      = ready_q;
    clearing     = 1'b0;
    wr_accept    = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = wr_r;
    mem_wdata    = wr_value;
    case (state_q)
      ST_CLEAR: begin
        clearing  = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        // Leave at the last entry instead of letting the pointer wrap.
        if (ptr_q == LAST_AW) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_RUN: begin
        wr_accept = wr_enable && ready_q;
        mem_we    = wr_accept;
      end
      default: begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end
    endcase
    branch_d     = wr_accept && (wr_r == PC_AW);
    wr_current_d = wr_accept ? wr_value : wr_current_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      ptr_q        <= '0;
      ready_q      <= !CLEAR_ON_RESET;
      branch_q     <= 1'b0;
      wr_current_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ready_q      <= ready_d;
      branch_q     <= branch_d;
      wr_current_q <= wr_current_d;
    end
  end

  assign ready      = ready_q;
  assign branch     = branch_q;
  assign wr_current = wr_current_q;

  generate
    for (genvar gi = 0; gi < int'(READ_PORTS); gi++) begin : g_copy
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] rd_value_q;
      logic [AW-1:0]    rd_addr;

      assign rd_addr = rd_r[gi*AW +: AW];

      // Plain synchronous write with no reset so each copy maps to block RAM.
      always_ff @(posedge clk) begin
        if (mem_we) begin
          mem_q[mem_waddr] <= mem_wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_value_q <= '0;
        end else if (clearing) begin
          rd_value_q <= '0;
        end else if (wr_accept && (wr_r == rd_addr)) begin
          rd_value_q <= wr_value;
        end else begin
          rd_value_q <= mem_q[rd_addr];
        end
      end

      assign rd_value[gi*WIDTH +: WIDTH] = rd_value_q;
    end
  endgenerate

endmodule

// File: tb/tb_core_regs_banked.sv
// Directed bench for core_regs_banked (DEPTH=16, three read ports):
// clear sequencing, bypass, PC-write flag and reset behaviour.
module tb_core_regs_banked;

  logic        clk;
  logic        rst_n;
  logic [11:0] rd_r;
  logic [95:0] rd_value;
  logic [3:0]  wr_r;
  logic        wr_enable;
  logic [31:0] wr_value;
  logic [31:0] wr_current;
  logic        branch;
  logic        ready;

  int total = 0;
  int bad   = 0;

  core_regs_banked #(
    .WIDTH(32), .DEPTH(16), .READ_PORTS(3), .PC_INDEX(15), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_r(rd_r), .rd_value(rd_value),
    .wr_r(wr_r), .wr_enable(wr_enable), .wr_value(wr_value),
    .wr_current(wr_current), .branch(branch), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("chk  %s: got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    rd_r = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rdp(input int p);
    return rd_value[p*32 +: 32];
  endfunction

  task automatic write(input logic [3:0] a, input logic [31:0] v);
    wr_enable = 1'b1;
    wr_r      = a;
    wr_value  = v;
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_enable = 1'b1;
    wr_r      = 4'd5;
    wr_value  = 32'h0000_AAAA;
    set_rd(4'd0, 4'd0, 4'd0);
    repeat (3) tick();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_wr_current", wr_current, 32'd0);
    check("rst_branch", {31'd0, branch}, 32'd0);
    check("rst_rd0", rdp(0), 32'd0);

    // Release, then pulse reset again at clear cycle 7.
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("clr1_ready_c%0d", c), {31'd0, ready}, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    check("midclr_rst_ready", {31'd0, ready}, 32'd0);
    check("midclr_rst_branch", {31'd0, branch}, 32'd0);
    check("midclr_rst_wr_current", wr_current, 32'd0);
    tick();
    rst_n = 1'b1;

    // Full clear: ready low for 15 edges, high from the 16th; write to r5 ignored.
    for (int c = 1; c <= 16; c++) begin
      tick();
      check($sformatf("clr2_ready_c%0d", c), {31'd0, ready}, (c == 16) ? 32'd1 : 32'd0);
      if (c == 8) check("clr2_rd1_zero", rdp(1), 32'd0);
    end
    wr_enable = 1'b0;
    check("clr_wr_current", wr_current, 32'd0);
    check("clr_branch", {31'd0, branch}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      set_rd(4'(i), 4'(i), 4'(i));
      tick();
      for (int p = 0; p < 3; p++)
        check($sformatf("zero_r%0d_p%0d", i, p), rdp(p), 32'd0);
    end

    // Same-cycle bypass.
    write(4'd3, 32'hDEAD_BEEF);
    set_rd(4'd3, 4'd4, 4'd3);
    tick();
    wr_enable = 1'b0;
    check("byp_p0", rdp(0), 32'hDEAD_BEEF);
    check("byp_p1", rdp(1), 32'd0);
    check("byp_p2", rdp(2), 32'hDEAD_BEEF);
    check("byp_wr_current", wr_current, 32'hDEAD_BEEF);
    check("byp_branch", {31'd0, branch}, 32'd0);
    tick();
    check("r3_stored", rdp(0), 32'hDEAD_BEEF);

    // PC write pulses branch for one cycle.
    write(4'd15, 32'h0000_1000);
    set_rd(4'd15, 4'd3, 4'd15);
    tick();
    wr_enable = 1'b0;
    check("pc_branch_hi", {31'd0, branch}, 32'd1);
    check("pc_byp_p0", rdp(0), 32'h0000_1000);
    tick();
    check("pc_branch_lo", {31'd0, branch}, 32'd0);
    check("pc_read_p0", rdp(0), 32'h0000_1000);
    check("pc_read_p1", rdp(1), 32'hDEAD_BEEF);
    check("pc_wr_current", wr_current, 32'h0000_1000);

    // Back-to-back PC writes keep branch high.
    write(4'd15, 32'h0000_2000);
    tick();
    check("pc2_branch_a", {31'd0, branch}, 32'd1);
    write(4'd15, 32'h0000_2004);
    tick();
    check("pc2_branch_b", {31'd0, branch}, 32'd1);
    write(4'd1, 32'h0000_0011);
    tick();
    check("nonpc_branch", {31'd0, branch}, 32'd0);
    check("nonpc_wr_current", wr_current, 32'h0000_0011);
    write(4'd2, 32'h0000_0022);
    tick();
    wr_enable = 1'b0;
    wr_value  = 32'h5555_5555;

    // Three ports, one-cycle latency, same-address ports agree.
    set_rd(4'd1, 4'd2, 4'd1);
    tick();
    check("mp_a_p0", rdp(0), 32'h0000_0011);
    check("mp_a_p1", rdp(1), 32'h0000_0022);
    check("mp_a_p2", rdp(2), 32'h0000_0011);
    check("hold_wr_current", wr_current, 32'h0000_0022);
    set_rd(4'd2, 4'd15, 4'd2);
    tick();
    check("mp_b_p0", rdp(0), 32'h0000_0022);
    check("mp_b_p1", rdp(1), 32'h0000_2004);
    check("mp_b_p2", rdp(2), 32'h0000_0022);

    // Reset mid-RUN: outputs clear at once, then a fresh clear sequence.
    write(4'd15, 32'h0000_3000);
    tick();
    wr_enable = 1'b0;
    rst_n = 1'b0;
    #1;
    check("run_rst_ready", {31'd0, ready}, 32'd0);
    check("run_rst_branch", {31'd0, branch}, 32'd0);
    check("run_rst_wr_current", wr_current, 32'd0);
    check("run_rst_rd0", rdp(0), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c >= 15) check($sformatf("clr3_ready_c%0d", c), {31'd0, ready}, (c == 16) ? 32'd1 : 32'd0);
    end
    set_rd(4'd3, 4'd1, 4'd15);
    tick();
    check("reclr_r3", rdp(0), 32'd0);
    check("reclr_r1", rdp(1), 32'd0);
    check("reclr_r15", rdp(2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
